// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Each granted byte is sequenced through issue (wr_en pulse), wait for busy to
// rise (with timeout) and wait for busy to fall. An optional burst lock keeps
// the grant on one requester until it delivers a byte flagged last.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 uart_din,
    output logic                       uart_wr_en,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      din_q, din_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            wr_en_q;
    logic            active_q;
    logic [NUM_REQ-1:0] ready_s;
    logic            win_found_s;
    logic [IW-1:0]   win_idx_s;

    // Index increment that wraps at NUM_REQ-1, also for non-power-of-two counts.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (idx == LAST_IDX) begin
            next_idx = {IW{1'b0}};
        end else begin
            next_idx = idx + IW'(1);
        end
    endfunction

    // Pick the first valid requester scanning upward from rr_ptr (wrapping).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int c;
            c = int'(rr_ptr_q) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end else begin
                c = c;
            end
            if (req_valid[c]) begin
                win_found_s = 1'b1;
                win_idx_s   = IW'(c);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic for the issue/busy sequence, grant capture and lock.
    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        ready_s  = {NUM_REQ{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (!uart_tx_busy && win_found_s) begin
                    ready_s[win_idx_s] = 1'b1;
                    din_d   = req_data[8*int'(win_idx_s) +: 8];
                    grant_d = win_idx_s;
                    lock_d  = ~req_last[win_idx_s];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                        err_d    = 1'b1;
                        lock_d   = 1'b0;
                        rr_ptr_d = next_idx(grant_q);
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_WAIT_BUSY;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (lock_q) begin
                        state_d = S_HOLD;
                    end else begin
                        rr_ptr_d = next_idx(grant_q);
                        state_d  = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_HOLD: begin
                if (req_valid[grant_q] && !uart_tx_busy) begin
                    ready_s[grant_q] = 1'b1;
                    din_d   = req_data[8*int'(grant_q) +: 8];
                    lock_d  = ~req_last[grant_q];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; wr_en and active are
    // registered from the next state so they line up with ISSUE / non-IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            din_q    <= 8'h00;
            grant_q  <= {IW{1'b0}};
            rr_ptr_q <= {IW{1'b0}};
            lock_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            err_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wr_en_q  <= (state_d == S_ISSUE);
            active_q <= (state_d != S_IDLE);
        end
    end

    assign req_ready   = rst ? {NUM_REQ{1'b0}} : ready_s;
    assign uart_din    = din_q;
    assign uart_wr_en  = wr_en_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART busy model and a
// scoreboard of expected (grant_id, byte) pairs popped on every wr_en pulse.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int BT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic [7:0]     uart_din;
    logic           uart_wr_en;
    logic           uart_tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;

    int checks   = 0;
    int failures = 0;
    int busy_len = 10;
    bit never_busy = 1'b0;
    int blen = 0;
    logic [NR-1:0] hs;
    logic [7:0] exp_data[$];
    logic [1:0] exp_id[$];

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .active       (active),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    // UART model: busy rises the edge after wr_en and stays up busy_len cycles.
    always @(posedge clk) begin
        if (uart_wr_en && !never_busy) begin
            uart_tx_busy <= 1'b1;
            blen         <= busy_len - 1;
        end else if (uart_tx_busy) begin
            if (blen == 0) uart_tx_busy <= 1'b0;
            else           blen <= blen - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d);
        exp_id.push_back(id);
        exp_data.push_back(d);
    endtask

    // One clock: record handshakes before the edge, check outputs after it.
    task automatic tick();
        #1;
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        chk("ready_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
        if (uart_wr_en === 1'b1) begin
            chk("sb_nonempty", {31'd0, exp_data.size() > 0}, 32'd1);
            if (exp_data.size() > 0) begin
                chk("din", {24'd0, uart_din}, {24'd0, exp_data.pop_front()});
                chk("grant_id", {30'd0, grant_id}, {30'd0, exp_id.pop_front()});
            end
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (active !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'd0, active}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"},   {24'd0, uart_din},    32'd0);
        chk({tag, "_wr"},    {31'd0, uart_wr_en},  32'd0);
        chk({tag, "_grant"}, {30'd0, grant_id},    32'd0);
        chk({tag, "_act"},   {31'd0, active},      32'd0);
        chk({tag, "_err"},   {31'd0, err_timeout}, 32'd0);
        chk({tag, "_ready"}, {28'd0, req_ready},   32'd0);
    endtask

    initial begin
        int acc, k, n;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        tick(); tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_no_wr", {31'd0, uart_wr_en}, 32'd0);
        end
        chk("idle_active", {31'd0, active}, 32'd0);

        // Single byte from requester 0.
        busy_len = 10;
        req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
        #1;
        chk("t2_ready", {28'd0, req_ready}, 32'h1);
        push(2'd0, 8'h41);
        tick();
        chk("t2_wr", {31'd0, uart_wr_en}, 32'd1);
        chk("t2_ready_issue", {28'd0, req_ready}, 32'd0);
        chk("t2_active", {31'd0, active}, 32'd1);
        req_valid = 4'b0000;
        wait_idle(40);
        chk("t2_drained", exp_data.size(), 32'd0);

        // Round robin with all four requesters valid.
        do_reset();
        busy_len = 3;
        req_valid = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_last = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push(2'(i), 8'(8'h10 + i));
        acc = 0; n = 0;
        while (acc < 8 && n < 200) begin
            tick();
            acc += $countones(hs);
            n++;
        end
        req_valid = 4'b0000;
        chk("t3_accepts", acc, 32'd8);
        wait_idle(40);
        chk("t3_drained", exp_data.size(), 32'd0);

        // Burst lock: req1 sends three bytes before req2 is served.
        do_reset();
        busy_len = 3;
        req_valid = 4'b0110; req_data = {8'h00, 8'hB2, 8'hA0, 8'h00}; req_last = 4'b0100;
        push(2'd1, 8'hA0); push(2'd1, 8'hA1); push(2'd1, 8'hA2); push(2'd2, 8'hB2);
        k = 0; n = 0;
        while (exp_data.size() > 0 && n < 300) begin
            tick();
            n++;
            if (hs[1]) begin
                k++;
                if (k == 3) req_valid[1] = 1'b0;
                else begin
                    req_data[15:8] = 8'(8'hA0 + k);
                    req_last[1] = (k == 2);
                end
            end
            if (hs[2]) req_valid[2] = 1'b0;
        end
        wait_idle(40);
        chk("t4_req1_bytes", k, 32'd3);
        chk("t4_drained", exp_data.size(), 32'd0);

        // Busy never rises: timeout clears lock and moves on to requester 1.
        do_reset();
        never_busy = 1'b1;
        req_valid = 4'b0011; req_data = {8'h00, 8'h00, 8'h51, 8'h50}; req_last = 4'b0000;
        #1;
        chk("t5_ready0", {28'd0, req_ready}, 32'h1);
        push(2'd0, 8'h50); push(2'd1, 8'h51);
        tick();
        tick();
        for (int j = 1; j <= BT; j++) begin
            tick();
            if (j < BT) chk("t5_err_low", {31'd0, err_timeout}, 32'd0);
            else begin
                chk("t5_err_pulse", {31'd0, err_timeout}, 32'd1);
                chk("t5_idle", {31'd0, active}, 32'd0);
            end
        end
        chk("t5_ready1", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_err2", {31'd0, err_timeout}, 32'd1);
        tick();
        chk("t5_err_one_cycle", {31'd0, err_timeout}, 32'd0);
        chk("t5_drained", exp_data.size(), 32'd0);
        never_busy = 1'b0;

        // Reset during WAIT_DONE with the lock held; re-arbitrate from index 0.
        busy_len = 10;
        req_valid = 4'b0101; req_data = {8'h00, 8'h62, 8'h00, 8'h60}; req_last = 4'b0001;
        #1;
        chk("t6_ready2", {28'd0, req_ready}, 32'h4);
        push(2'd2, 8'h62);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        push(2'd0, 8'h60);
        hs = '0;
        n = 0;
        while (hs == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        chk("t6_winner", {28'd0, hs}, 32'h1);
        req_valid = 4'b0000;
        wait_idle(40);
        chk("t6_drained", exp_data.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
